dht11_reader: RTL and testbench

Hardware single-wire protocol engine for DHT11/DHT22-class sensors, exposed as an Avalon-MM slave. It replaces software bit-banging of a bidirectional PIO. On a start command it drives the start pulse and decodes the sensor response plus 40 data bits by pulse-width timing. It then verifies the checksum and presents humidity/temperature in registers. Open-drain drive of one bidir pin; the block owns all timing.

---
 rtl/dht11_reader_if.sv | 25 ++
 rtl/dht11_reader.sv | 164 ++++++++++++++++
 tb/tb_dht11_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dht11_reader_if
// Description : Avalon-MM slave bus bundle for the DHT11/DHT22 reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface dht11_reader_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/dht11_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dht11_reader
// Description : DHT11/DHT22 single-wire protocol engine with Avalon-MM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module dht11_reader #(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dht11_reader_if.slave bus,
    inout  wire           bidir_port
);

    localparam int C_TICK_DIV = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
    localparam int C_PRE_W    = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FAIL, S_DONE
    } state_t;

    state_t             r_state, w_next;
    logic               r_sync1, r_sync2, r_prev;
    logic [C_PRE_W-1:0] r_pre_cnt;
    logic [15:0]        r_us;
    logic [5:0]         r_bit_idx;
    logic [39:0]        r_shift;
    logic [31:0]        r_data;
    logic [7:0]         r_checksum;
    logic               r_busy, r_done;
    logic [1:0]         r_err;
    logic [31:0]        r_readdata;

    logic w_tick, w_rise, w_fall, w_start_end, w_timeout;
    logic w_write, w_clear, w_start, w_sum_ok;
    logic [7:0] w_sum;
    logic w_unused_bits;

    assign w_unused_bits = &{1'b0, bus.writedata[31:2]};

    assign w_tick      = (r_pre_cnt == C_PRE_W'(C_TICK_DIV - 1));
    assign w_rise      = r_sync2 & ~r_prev;
    assign w_fall      = ~r_sync2 & r_prev;
    // Limits fire on the tick that brings the count up to the target value.
    assign w_start_end = w_tick && (r_us == 16'(START_LOW_US - 1));
    assign w_timeout   = w_tick && (r_us == 16'(TIMEOUT_US - 1));

    assign w_write  = bus.chipselect & ~bus.write_n & (bus.address == 2'd0);
    assign w_clear  = w_write & bus.writedata[1];
    assign w_start  = w_write & bus.writedata[0] & ~r_busy;
    assign w_sum    = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_sum_ok = (w_sum == r_shift[7:0]);

    assign bidir_port   = (r_state == S_START_LOW) ? 1'b0 : 1'bz;
    assign bus.readdata = r_readdata;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next = S_START_LOW;
            S_START_LOW: if (w_start_end) w_next = S_RELEASE;
            S_RELEASE:   if (w_fall) w_next = S_RESP_LOW;  else if (w_timeout) w_next = S_FAIL;
            S_RESP_LOW:  if (w_rise) w_next = S_RESP_HIGH; else if (w_timeout) w_next = S_FAIL;
            S_RESP_HIGH: if (w_fall) w_next = S_BIT_LOW;   else if (w_timeout) w_next = S_FAIL;
            S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;  else if (w_timeout) w_next = S_FAIL;
            S_BIT_HIGH: begin
                if (w_fall)         w_next = (r_bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (w_timeout) w_next = S_FAIL;
            end
            S_CHECK:     w_next = S_DONE;
            S_FAIL:      w_next = S_IDLE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_pre_cnt  <= '0;
            r_us       <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_checksum <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 2'd0;
            r_readdata <= '0;
        end else begin
            r_sync1   <= bidir_port;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;

            if (w_next != r_state)                r_us <= '0;
            else if (w_tick && r_us != 16'hFFFF)  r_us <= r_us + 16'd1;

            case (bus.address)
                2'd0:    r_readdata <= {28'd0, r_err, r_done, r_busy};
                2'd1:    r_readdata <= r_data;
                2'd2:    r_readdata <= {24'd0, r_checksum};
                default: r_readdata <= {31'd0, r_sync2};
            endcase

            // Clear is applied before start so a combined write both clears and starts.
            if (w_clear) begin
                r_done <= 1'b0;
                r_err  <= 2'd0;
            end
            if (w_start) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 2'd0;
            end

            case (r_state)
                S_RELEASE, S_RESP_LOW: if (w_next == S_FAIL) r_err <= 2'd1;
                S_RESP_HIGH: begin
                    if (w_fall)                 r_bit_idx <= '0;
                    else if (w_next == S_FAIL)  r_err     <= 2'd1;
                end
                S_BIT_LOW: if (w_next == S_FAIL) r_err <= 2'd2;
                S_BIT_HIGH: begin
                    if (w_fall) begin
                        r_shift   <= {r_shift[38:0], (r_us > 16'(BIT_THRESH_US))};
                        r_bit_idx <= r_bit_idx + 6'd1;
                    end else if (w_next == S_FAIL) begin
                        r_err <= 2'd2;
                    end
                end
                S_CHECK: begin
                    r_checksum <= r_shift[7:0];
                    if (w_sum_ok) begin
                        r_data <= r_shift[39:8];
                        r_err  <= 2'd0;
                    end else begin
                        r_err  <= 2'd3;
                    end
                end
                S_FAIL, S_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dht11_reader
// Description : Self-checking bench for dht11_reader with a cycle-level sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_reader;

    localparam int START_LOW_US = 20;
    localparam int TIMEOUT_US   = 100;

    typedef struct {
        logic [39:0] frame;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        logic [31:0] exp_a2;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sens_low = 1'b0;
    wire  bidir_port;
    int   checks = 0;
    int   passed = 0;
    logic [31:0] m_data;
    vec_t vecs[4];

    dht11_reader_if bus();

    dht11_reader #(
        .CLK_FREQ_HZ  (1000000),
        .START_LOW_US (START_LOW_US),
        .TIMEOUT_US   (TIMEOUT_US),
        .BIT_THRESH_US(40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .bidir_port (bidir_port)
    );

    pullup (bidir_port);
    assign bidir_port = sens_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(posedge clk);
        #1 d = bus.readdata;
    endtask

    task automatic hold(input logic low, input int n);
        sens_low = low;
        repeat (n) @(negedge clk);
    endtask

    // Sensor: waits for the host start pulse, answers 80/80, then sends nbits MSB first.
    task automatic run_frame(input logic [39:0] frame, input int nbits);
        int n;
        bus_write(2'd0, 32'd1);
        n = 0;
        while (bidir_port !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) bound_fail("start_low_seen");
        n = 0;
        while (bidir_port !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) bound_fail("start_release_seen");
        hold(1'b0, 10);
        hold(1'b1, 80);
        hold(1'b0, 80);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b1, 50);
            hold(1'b0, frame[39-i] ? 70 : 26);
        end
        if (nbits == 40) hold(1'b1, 50);
        sens_low = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] a0);
        int n;
        n = 0;
        a0 = '0;
        while (n < 1000) begin
            bus_read(2'd0, a0);
            if (a0[1]) break;
            n++;
        end
        if (n >= 1000) bound_fail("wait_done");
    endtask

    // Reference: byte-wise checksum over the received frame.
    task automatic model_frame(input logic [39:0] f, output logic [31:0] e0,
                               output logic [31:0] e1, output logic [31:0] e2);
        int s;
        s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        if (s == int'(f[7:0])) begin
            m_data = f[39:8];
            e0 = 32'h2;
        end else begin
            e0 = 32'hE;
        end
        e1 = m_data;
        e2 = {24'd0, f[7:0]};
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] d;
        wait_done(d);
        check({tag, "_status"}, d, e0);
        bus_read(2'd1, d);
        check({tag, "_data"}, d, e1);
        bus_read(2'd2, d);
        check({tag, "_checksum"}, d, e2);
    endtask

    initial begin
        logic [31:0] d, e0, e1, e2;
        logic [39:0] f;
        logic [7:0]  b1, b2, b3, b4, s8;
        int lowcnt, done_at;
        bit busy_seen;

        vecs[0] = '{40'h37_00_19_00_50, 32'h2, 32'h37001900, 32'h50};
        vecs[1] = '{40'h37_00_19_00_51, 32'hE, 32'h37001900, 32'h51};
        vecs[2] = '{40'hFF_01_80_7F_FF, 32'h2, 32'hFF01807F, 32'hFF};
        vecs[3] = '{40'h00_00_00_00_01, 32'hE, 32'hFF01807F, 32'h01};

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        bus_read(2'd0, d); check("reset_status", d, 32'h0);
        bus_read(2'd1, d); check("reset_data", d, 32'h0);
        bus_read(2'd2, d); check("reset_checksum", d, 32'h0);
        bus_read(2'd3, d); check("reset_line", d, 32'h1);

        // Start pulse length and no-response timeout.
        bus_write(2'd0, 32'd1);
        bus.address = 2'd0;
        lowcnt = 0; busy_seen = 0; done_at = -1;
        for (int n = 1; n <= 300 && done_at < 0; n++) begin
            @(negedge clk);
            if (bidir_port === 1'b0) lowcnt++;
            if (bus.readdata[0]) busy_seen = 1'b1;
            if (bus.readdata[1]) done_at = n;
        end
        check("start_low_cycles", lowcnt, START_LOW_US);
        check("busy_seen", {31'd0, busy_seen}, 32'd1);
        check("noresp_window", {31'd0, (done_at >= START_LOW_US + TIMEOUT_US &&
                                        done_at <= START_LOW_US + TIMEOUT_US + 6)}, 32'd1);
        bus_read(2'd0, d); check("noresp_status", d, 32'h6);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].frame, 40);
            check_regs($sformatf("vec%0d", i), vecs[i].exp_a0, vecs[i].exp_a1, vecs[i].exp_a2);
        end
        m_data = vecs[3].exp_a1;

        for (int i = 0; i < 4; i++) begin
            b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); b4 = 8'($urandom);
            s8 = b1 + b2 + b3 + b4;
            if ($urandom_range(0, 1) == 1) s8 = s8 + 8'($urandom_range(1, 255));
            f = {b4, b3, b2, b1, s8};
            run_frame(f, 40);
            model_frame(f, e0, e1, e2);
            check_regs($sformatf("rand%0d", i), e0, e1, e2);
        end

        // Start request in the middle of a frame must not disturb it.
        f = 40'h12_34_56_78_14;
        fork
            run_frame(f, 40);
            begin
                repeat (800) @(negedge clk);
                bus_write(2'd0, 32'd1);
            end
        join
        model_frame(f, e0, e1, e2);
        check_regs("busy_restart", e0, e1, e2);

        // Sensor goes quiet after bit 12.
        run_frame(40'hAA_55_AA_55_FF, 13);
        wait_done(d);
        check("bit_timeout_status", d, 32'hA);
        bus_write(2'd0, 32'd2);
        bus_read(2'd0, d);
        check("clear_status", d, 32'h0);

        // Reset in the middle of the start pulse.
        bus_write(2'd0, 32'd1);
        repeat (5) @(negedge clk);
        check("pre_reset_low", {31'd0, bidir_port}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 check("reset_releases_line", {31'd0, bidir_port}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.address = 2'd0;
        @(posedge clk);
        #1 check("post_reset_status", bus.readdata, 32'h0);
        @(negedge clk);
        bus.address = 2'd1;
        @(posedge clk);
        #1 check("post_reset_data", bus.readdata, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
